// File: rtl/pending_priority_encoder.sv
// Pending-request priority encoder: sticky per-source pending bits, an
// eligibility mask, and a valid/ready offer of the winning source index.
// Fixed priority (highest index wins) or round-robin selection.
module pending_priority_encoder #(
  parameter int N       = 8,
  parameter int IDXW    = $clog2(N),
  parameter bit RR_MODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic            clr_all,
  input  logic            ready_in,
  output logic            valid_out,
  output logic [IDXW-1:0] idx_out,
  output logic [N-1:0]    pending_out,
  output logic            drop_out
);

  localparam int unsigned NU = N;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t          state_q,   state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic            valid_q,   valid_d;
  logic [IDXW-1:0] idx_q,     idx_d;
  logic            drop_q,    drop_d;
  logic [IDXW-1:0] rr_ptr_q,  rr_ptr_d;

  logic            accept;
  logic [N-1:0]    clr_vec;
  logic [N-1:0]    elig;
  logic [N-1:0]    nxt;

  // Winner of v. Round-robin searches downward starting just below ptr,
  // wrapping from 0 to N-1, so ptr itself is examined last.
  function automatic logic [IDXW-1:0] select_idx(input logic [N-1:0]    v,
                                                 input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] res;
    logic            found;
    int unsigned     pos;
    res   = '0;
    found = 1'b0;
    if (!RR_MODE) begin
      for (int unsigned i = 0; i < NU; i++) begin
        if (v[i]) res = IDXW'(i);
      end
    end else begin
      for (int unsigned k = 1; k <= NU; k++) begin
        pos = (32'(ptr) + NU - k) % NU;
        if (!found && v[pos]) begin
          res   = IDXW'(pos);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Next-state computation: pending update, drop detection and offer FSM.
  always_comb begin
    accept    = valid_q & ready_in;
    clr_vec   = accept ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
    elig      = pending_q & mask;
    nxt       = elig & ~clr_vec;
    pending_d = clr_all ? '0 : ((pending_q & ~clr_vec) | req);
    drop_d    = (|(req & pending_q & ~clr_vec)) & ~clr_all;
    rr_ptr_d  = accept ? idx_q : rr_ptr_q;
    state_d   = state_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          idx_d   = select_idx(elig, rr_ptr_q);
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // The search after an accept starts from the granted index, which is
        // the value rr_ptr takes on this same edge.
        if (accept) begin
          if (|nxt) begin
            idx_d = select_idx(nxt, idx_q);
          end else begin
            idx_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (clr_all) begin
      idx_d   = '0;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      drop_q    <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      drop_q    <= drop_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign valid_out   = valid_q;
  assign idx_out     = idx_q;
  assign pending_out = pending_q;
  assign drop_out    = drop_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Scoreboard bench for pending_priority_encoder: a fixed-priority and a
// round-robin instance share stimulus; a reference model predicts each
// post-edge output set, a monitor pops and compares on the falling edge.
module tb_pending_priority_encoder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask;
  logic       clr_all, ready_in;

  logic       v0, v1, d0, d1;
  logic [2:0] i0, i1;
  logic [7:0] p0, p1;

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(8), .RR_MODE(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .clr_all(clr_all),
    .ready_in(ready_in), .valid_out(v0), .idx_out(i0), .pending_out(p0),
    .drop_out(d0));

  pending_priority_encoder #(.N(8), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .clr_all(clr_all),
    .ready_in(ready_in), .valid_out(v1), .idx_out(i1), .pending_out(p1),
    .drop_out(d1));

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [7:0] p;
    logic       d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin.
  bit [7:0] m_pend[2];
  bit       m_valid[2];
  int       m_idx[2];
  bit       m_drop[2];
  int       m_ptr[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0; m_valid[d] = 1'b0; m_idx[d] = 0;
      m_drop[d] = 1'b0; m_ptr[d] = 0;
    end
  endfunction

  function automatic int pick(int mode, bit [7:0] v, int start);
    if (mode == 0) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (start + N - k) % N;
        if (v[i]) return i;
      end
    end
    return 0;
  endfunction

  function automatic void model_step(int d, bit [7:0] r, bit [7:0] mk, bit c, bit rd);
    bit       acc;
    int       gone;
    bit [7:0] np;
    bit       nd;
    bit [7:0] elig;
    bit [7:0] cand;
    acc  = m_valid[d] && rd;
    gone = acc ? m_idx[d] : -1;
    np   = '0;
    nd   = 1'b0;
    for (int i = 0; i < N; i++) begin
      np[i] = !c && ((m_pend[d][i] && i != gone) || r[i]);
      if (r[i] && m_pend[d][i] && i != gone) nd = 1'b1;
    end
    nd   = nd && !c;
    elig = m_pend[d] & mk;
    if (c) begin
      m_valid[d] = 1'b0; m_idx[d] = 0;
    end else if (!m_valid[d]) begin
      if (elig != 0) begin
        m_idx[d] = pick(d, elig, m_ptr[d]); m_valid[d] = 1'b1;
      end
    end else if (acc) begin
      cand = elig;
      cand[gone] = 1'b0;
      if (cand != 0) m_idx[d] = pick(d, cand, gone);
      else begin m_valid[d] = 1'b0; m_idx[d] = 0; end
    end
    if (acc) m_ptr[d] = gone;
    m_pend[d] = np;
    m_drop[d] = nd;
  endfunction

  function automatic exp_t model_exp(int d);
    exp_t e;
    e.v = m_valid[d]; e.idx = 3'(m_idx[d]); e.p = m_pend[d]; e.d = m_drop[d];
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t e, input logic v,
                     input logic [2:0] idx, input logic [7:0] p, input logic d);
    checks += 4;
    if (v !== e.v) begin
      errors++; $display("FAIL %s valid_out got %b exp %b at %0t", nm, v, e.v, $time);
    end
    if (idx !== e.idx) begin
      errors++; $display("FAIL %s idx_out got %0d exp %0d at %0t", nm, idx, e.idx, $time);
    end
    if (p !== e.p) begin
      errors++; $display("FAIL %s pending_out got %h exp %h at %0t", nm, p, e.p, $time);
    end
    if (d !== e.d) begin
      errors++; $display("FAIL %s drop_out got %b exp %b at %0t", nm, d, e.d, $time);
    end
  endtask

  // Monitor: compare each predicted post-edge state on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q1.size() > 0) begin
      e = q0.pop_front(); chk("fix", e, v0, i0, p0, d0);
      e = q1.pop_front(); chk("rr", e, v1, i1, p1, d1);
    end
  end

  // One clock of stimulus; called #1 after a rising edge.
  task automatic cyc(input logic [7:0] r, input logic [7:0] mk, input logic c, input logic rd);
    exp_t e0, e1;
    req = r; mask = mk; clr_all = c; ready_in = rd;
    model_step(0, r, mk, c, rd);
    model_step(1, r, mk, c, rd);
    e0 = model_exp(0);
    e1 = model_exp(1);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int k = 0; k < n; k++) cyc(8'h00, 8'hFF, 1'b0, rd);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    exp_t z;
    z = '0;
    req = '0; mask = '0; clr_all = 1'b0; ready_in = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fix", z, v0, i0, p0, d0);
    chk("async_rst_rr", z, v1, i1, p1, d1);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t z;
    z = '0;
    rst_n = 1'b0;
    req = '0; mask = '0; clr_all = 1'b0; ready_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fix", z, v0, i0, p0, d0);
    chk("reset_rr", z, v1, i1, p1, d1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two requests in one pulse, consumer always ready.
    cyc(8'h00, 8'hFF, 1'b0, 1'b1);
    cyc(8'h24, 8'hFF, 1'b0, 1'b1);
    idle(4, 1'b1);

    // No preemption of a held offer.
    cyc(8'h04, 8'hFF, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(8'h80, 8'hFF, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // All sources pending, round-robin sweep with a re-pulse after grant 7.
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 1'b0, 1'b1);
    cyc(8'h81, 8'hFF, 1'b0, 1'b1);
    idle(10, 1'b1);

    // Drop on repeated request; no drop when re-requested on its accept.
    cyc(8'h08, 8'hFF, 1'b0, 1'b0);
    cyc(8'h08, 8'hFF, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(8'h08, 8'hFF, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Masked sources stay pending but are not offered.
    cyc(8'hF0, 8'h0F, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(8'h00, 8'h0F, 1'b0, 1'b1);
    idle(6, 1'b1);

    // clr_all beats simultaneous requests; then async reset mid-offer.
    cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    cyc(8'h81, 8'hFF, 1'b0, 1'b0);
    idle(2, 1'b0);
    async_reset();
    idle(2, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      logic [7:0] r, mk;
      logic       c, rd;
      r  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      c  = ($urandom_range(0, 60) == 0);
      rd = ($urandom_range(0, 2) != 0);
      cyc(r, mk, c, rd);
      if ($urandom_range(0, 700) == 0) async_reset();
    end

    @(negedge clk); #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain queue sizes got %0d/%0d exp 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
